// File: rtl/imm_ext_pkg.sv
// Shared extension-opcode encodings and the opcode legality helper for imm_ext_pipe.
package imm_ext_pkg;

    localparam int EXT_OP_W = 3;

    localparam logic [EXT_OP_W-1:0] EXT_ZERO  = 3'd0;
    localparam logic [EXT_OP_W-1:0] EXT_SIGN  = 3'd1;
    localparam logic [EXT_OP_W-1:0] EXT_LUI   = 3'd2;
    localparam logic [EXT_OP_W-1:0] EXT_BROFF = 3'd3;
    localparam logic [EXT_OP_W-1:0] EXT_SHAMT = 3'd4;

    function automatic logic is_legal_extop(input logic [EXT_OP_W-1:0] op);
        return (op <= EXT_SHAMT);
    endfunction

endpackage

// File: rtl/imm_ext_core.sv
// Purely combinational immediate extender: maps (imm, extop) to a DATA_W operand plus an illegal flag.
module imm_ext_core
    import imm_ext_pkg::*;
#(
    parameter int IMM_W  = 16,
    parameter int DATA_W = 32,
    parameter int OP_W   = 3
) (
    input  logic [IMM_W-1:0]  imm,
    input  logic [OP_W-1:0]   extop,
    output logic [DATA_W-1:0] value,
    output logic              illegal
);

    logic [EXT_OP_W-1:0] op_s;
    logic [DATA_W-1:0]   zext_s;
    logic [DATA_W-1:0]   sext_s;

    assign op_s   = EXT_OP_W'(extop);
    assign zext_s = {{(DATA_W-IMM_W){1'b0}}, imm};
    assign sext_s = {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};

    // Mode select; undefined opcodes fall back to zero extension and raise illegal.
    always_comb begin
        value   = zext_s;
        illegal = !is_legal_extop(op_s);
        case (op_s)
            EXT_ZERO:  value = zext_s;
            EXT_SIGN:  value = sext_s;
            EXT_LUI:   value = {imm, {(DATA_W-IMM_W){1'b0}}};
            EXT_BROFF: value = {sext_s[DATA_W-3:0], 2'b00};
            EXT_SHAMT: value = {{(DATA_W-5){1'b0}}, imm[10:6]};
            default:   value = zext_s;
        endcase
    end

endmodule

// File: rtl/imm_ext_pipe.sv
// Pipelined immediate-extension stage with a 2-entry (main + skid) buffer and flush.
// Optional macro IMM_EXT_BYPASS_EN adds a zero-latency path when the stage is empty.
module imm_ext_pipe
    import imm_ext_pkg::*;
#(
    parameter int IMM_W  = 16,
    parameter int DATA_W = 32,
    parameter int OP_W   = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [OP_W-1:0]   in_extop,
    input  logic [IMM_W-1:0]  in_imm,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_imm,
    output logic              out_illegal
);

    logic [DATA_W-1:0] ext_value_s;
    logic              ext_illegal_s;

    logic              m_valid_r;
    logic [DATA_W-1:0] m_imm_r;
    logic              m_ill_r;
    logic              s_valid_r;
    logic [DATA_W-1:0] s_imm_r;
    logic              s_ill_r;

    logic              in_fire_s;
    logic              m_pop_s;
    logic              bypass_s;
    logic              load_s;

    imm_ext_core #(
        .IMM_W  (IMM_W),
        .DATA_W (DATA_W),
        .OP_W   (OP_W)
    ) u_core (
        .imm     (in_imm),
        .extop   (in_extop),
        .value   (ext_value_s),
        .illegal (ext_illegal_s)
    );

    assign in_ready  = !s_valid_r;
    assign in_fire_s = in_valid && in_ready;
    assign m_pop_s   = m_valid_r && out_ready;

`ifdef IMM_EXT_BYPASS_EN
    assign bypass_s = !m_valid_r && !s_valid_r && in_valid && out_ready && !flush;

    // Bypassed results are handed straight to the consumer and never stored.
    always_comb begin
        if (bypass_s) begin
            out_valid   = 1'b1;
            out_imm     = ext_value_s;
            out_illegal = ext_illegal_s;
        end else begin
            out_valid   = m_valid_r;
            out_imm     = m_imm_r;
            out_illegal = m_ill_r;
        end
    end
`else
    assign bypass_s    = 1'b0;
    assign out_valid   = m_valid_r;
    assign out_imm     = m_imm_r;
    assign out_illegal = m_ill_r;
`endif

    assign load_s = in_fire_s && !bypass_s;

    // Main/skid storage: FIFO order, S refills M on a pop, flush drops everything.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            m_valid_r <= 1'b0;
            m_imm_r   <= {DATA_W{1'b0}};
            m_ill_r   <= 1'b0;
            s_valid_r <= 1'b0;
            s_imm_r   <= {DATA_W{1'b0}};
            s_ill_r   <= 1'b0;
        end else if (flush) begin
            m_valid_r <= 1'b0;
            s_valid_r <= 1'b0;
        end else if (m_pop_s) begin
            if (s_valid_r) begin
                m_imm_r   <= s_imm_r;
                m_ill_r   <= s_ill_r;
                s_valid_r <= 1'b0;
            end else if (load_s) begin
                m_imm_r <= ext_value_s;
                m_ill_r <= ext_illegal_s;
            end else begin
                m_valid_r <= 1'b0;
            end
        end else if (load_s) begin
            if (!m_valid_r) begin
                m_valid_r <= 1'b1;
                m_imm_r   <= ext_value_s;
                m_ill_r   <= ext_illegal_s;
            end else begin
                s_valid_r <= 1'b1;
                s_imm_r   <= ext_value_s;
                s_ill_r   <= ext_illegal_s;
            end
        end
    end

endmodule
